divider_core: RTL and testbench

- Sequential signed shift-subtract (restoring) divider, WIDTH-bit.
- It is the inverse counterpart of the lab's shift-add multiplier datapath.
- It takes synchronized switch/button-derived operands and a level Run, and iterates one quotient bit per clock.
- It presents registered quotient/remainder for the hex display path.

---
 rtl/divider_core.sv | 134 +++++++++++++
 tb/tb_divider_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/divider_core.sv
// Sequential signed restoring divider: one quotient bit per clock on magnitudes,
// sign fix-up in a final cycle, registered quotient/remainder for the display path.
module divider_core #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             Reset_Load_Clear_n,
   input  logic             Run,
   input  logic [WIDTH-1:0] Dividend_In,
   input  logic [WIDTH-1:0] Divisor_In,
   output logic [WIDTH-1:0] Qval,
   output logic [WIDTH-1:0] Rval,
   output logic             Busy,
   output logic             Done,
   output logic             Div_By_Zero,
   output logic             Overflow
);

   // state | meaning
   // IDLE  | waiting for Run; last result and flags held
   // CALC  | WIDTH shift-subtract iterations on magnitudes
   // FIX   | apply signs, handle divide-by-zero and overflow
   // DONE  | result valid; wait for Run low before re-arming

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH:0]   MAG_ONE  = (WIDTH+1)'(1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   q_reg;
   logic [WIDTH:0]   m_reg;
   logic [WIDTH:0]   p_reg;
   logic             sign_q;
   logic             sign_r;
   logic [WIDTH-1:0] dvd_cap;

   logic [WIDTH:0]   dvd_abs;
   logic [WIDTH:0]   dsr_abs;
   logic [WIDTH:0]   p_sh;
   logic [WIDTH+1:0] trial;
   logic [WIDTH-1:0] q_mag;
   logic [WIDTH-1:0] r_mag;
   logic             div_zero;
   logic             ovf;
   logic             unused_bits;

   // Magnitudes are one bit wider so the most negative operand stays representable.
   assign dvd_abs = Dividend_In[WIDTH-1] ? -{Dividend_In[WIDTH-1], Dividend_In}
                                         : {1'b0, Dividend_In};
   assign dsr_abs = Divisor_In[WIDTH-1]  ? -{Divisor_In[WIDTH-1], Divisor_In}
                                         : {1'b0, Divisor_In};

   // |dividend| never exceeds 2^(WIDTH-1), so bit WIDTH-1 is the first bit consumed.
   assign p_sh  = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
   assign trial = {1'b0, p_sh} - {1'b0, m_reg};
   assign q_mag = q_reg[WIDTH-1:0];
   assign r_mag = p_reg[WIDTH-1:0];

   assign div_zero    = (m_reg == '0);
   assign ovf         = (dvd_cap == MOST_NEG) && (m_reg == MAG_ONE) && sign_r && !sign_q;
   assign unused_bits = ^{p_reg[WIDTH], q_reg[WIDTH]};

   assign Busy = (state == CALC) || (state == FIX);
   assign Done = (state == DONE);

   always_ff @(posedge CLK or negedge Reset_Load_Clear_n) begin
      if (!Reset_Load_Clear_n) begin
         state       <= IDLE;
         cnt         <= '0;
         q_reg       <= '0;
         m_reg       <= '0;
         p_reg       <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dvd_cap     <= '0;
         Qval        <= '0;
         Rval        <= '0;
         Div_By_Zero <= 1'b0;
         Overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Run) begin
                  state       <= CALC;
                  sign_q      <= Dividend_In[WIDTH-1] ^ Divisor_In[WIDTH-1];
                  sign_r      <= Dividend_In[WIDTH-1];
                  q_reg       <= dvd_abs;
                  m_reg       <= dsr_abs;
                  p_reg       <= '0;
                  cnt         <= '0;
                  dvd_cap     <= Dividend_In;
                  Div_By_Zero <= 1'b0;
                  Overflow    <= 1'b0;
               end
            end
            CALC: begin
               if (!trial[WIDTH+1]) begin
                  p_reg <= trial[WIDTH:0];
                  q_reg <= {q_reg[WIDTH-1:0], 1'b1};
               end else begin
                  p_reg <= p_sh;
                  q_reg <= {q_reg[WIDTH-1:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) state <= FIX;
            end
            FIX: begin
               state <= DONE;
               if (div_zero) begin
                  Qval        <= '1;
                  Rval        <= dvd_cap;
                  Div_By_Zero <= 1'b1;
               end else if (ovf) begin
                  Qval     <= MOST_NEG;
                  Rval     <= '0;
                  Overflow <= 1'b1;
               end else begin
                  Qval <= sign_q ? -q_mag : q_mag;
                  Rval <= sign_r ? -r_mag : r_mag;
               end
            end
            DONE: begin
               if (!Run) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_core.sv
// Self-checking bench for divider_core: directed vector table, random operands
// against an integer-arithmetic model, and hand sequences for Run-hold and reset.
module tb_divider_core;

   logic       CLK = 1'b0;
   logic       Reset_Load_Clear_n = 1'b0;
   logic       Run = 1'b0;
   logic [7:0] Dividend_In = '0;
   logic [7:0] Divisor_In = '0;
   logic [7:0] Qval;
   logic [7:0] Rval;
   logic       Busy;
   logic       Done;
   logic       Div_By_Zero;
   logic       Overflow;

   int n_checks = 0;
   int n_fail   = 0;

   divider_core #(.WIDTH(8)) dut (
      .CLK               (CLK),
      .Reset_Load_Clear_n(Reset_Load_Clear_n),
      .Run               (Run),
      .Dividend_In       (Dividend_In),
      .Divisor_In        (Divisor_In),
      .Qval              (Qval),
      .Rval              (Rval),
      .Busy              (Busy),
      .Done              (Done),
      .Div_By_Zero       (Div_By_Zero),
      .Overflow          (Overflow)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] eq;
      logic [7:0] er;
      logic       edz;
      logic       eov;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] q, output logic [7:0] r,
                                 output logic dz, output logic ov);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      dz = (sb == 0);
      ov = (sa == -128) && (sb == -1);
      if (dz) begin
         q = 8'hFF;
         r = a;
      end else if (ov) begin
         q = 8'h80;
         r = 8'h00;
      end else begin
         q = 8'(sa / sb);
         r = 8'(sa % sb);
      end
   endfunction

   // Called at a negedge with the DUT idle. Returns the edge number (start edge = 1)
   // after which Done was first seen, or 0 if it never came.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold,
                         output int lat);
      Dividend_In = a;
      Divisor_In  = b;
      Run         = 1'b1;
      lat         = 0;
      for (int e = 1; e <= 30; e++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (e == 1) begin
            check("busy_after_start", {31'd0, Busy}, 32'd1);
            Dividend_In = 8'($urandom);
            Divisor_In  = 8'($urandom);
            if (!hold) Run = 1'b0;
         end
         if (Done) begin
            lat = e;
            break;
         end
      end
   endtask

   task automatic check_result(input string tag, input logic [7:0] eq, input logic [7:0] er,
                               input logic edz, input logic eov, input int lat);
      check({tag, "_latency"}, lat, 32'd10);
      check({tag, "_q"}, {24'd0, Qval}, {24'd0, eq});
      check({tag, "_r"}, {24'd0, Rval}, {24'd0, er});
      check({tag, "_flags"}, {30'd0, Div_By_Zero, Overflow}, {30'd0, edz, eov});
   endtask

   task automatic to_idle();
      Run = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      int         lat;
      logic [7:0] a, b, eq, er;
      logic       edz, eov;
      int         bad;

      vecs[0] = '{8'd7,    8'd2,    8'h03, 8'h01, 1'b0, 1'b0};
      vecs[1] = '{8'hF9,   8'd2,    8'hFD, 8'hFF, 1'b0, 1'b0};
      vecs[2] = '{8'h64,   8'hF9,   8'hF2, 8'h02, 1'b0, 1'b0};
      vecs[3] = '{8'h80,   8'hFF,   8'h80, 8'h00, 1'b0, 1'b1};
      vecs[4] = '{8'h80,   8'h01,   8'h80, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{8'd5,    8'd0,    8'hFF, 8'h05, 1'b1, 1'b0};
      vecs[6] = '{8'd9,    8'd3,    8'h03, 8'h00, 1'b0, 1'b0};
      vecs[7] = '{8'hF9,   8'hFE,   8'h03, 8'hFF, 1'b0, 1'b0};

      // Reset held with Run high: nothing may move.
      Run = 1'b1;
      Dividend_In = 8'd7;
      Divisor_In  = 8'd2;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("reset_outputs", {Qval, Rval, 4'd0, Busy, Done, Div_By_Zero, Overflow}, 32'd0);
      Run = 1'b0;
      Reset_Load_Clear_n = 1'b1;
      @(negedge CLK);
      check("idle_after_reset", {30'd0, Busy, Done}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, (i == 0), lat);
         check_result($sformatf("vec%0d", i), vecs[i].eq, vecs[i].er, vecs[i].edz, vecs[i].eov, lat);
         to_idle();
         check($sformatf("vec%0d_hold_idle", i), {24'd0, Qval}, {24'd0, vecs[i].eq});
      end

      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom);
         b = (i % 10 == 3) ? 8'd0 : 8'($urandom);
         model(a, b, eq, er, edz, eov);
         run_op(a, b, 1'b0, lat);
         check_result($sformatf("rnd%0d", i), eq, er, edz, eov, lat);
         to_idle();
      end

      // Run held high for 40 cycles: exactly one operation.
      run_op(8'd20, 8'd6, 1'b1, lat);
      check_result("hold", 8'd3, 8'd2, 1'b0, 1'b0, lat);
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (!Done || Busy || Qval != 8'd3) bad++;
      end
      check("hold_single_op", bad, 32'd0);
      to_idle();
      check("hold_release_idle", {30'd0, Busy, Done}, 32'd0);

      // Reset in the middle of CALC with scrambled operands.
      Dividend_In = 8'd9;
      Divisor_In  = 8'd2;
      Run = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      Dividend_In = 8'd77;
      Divisor_In  = 8'd5;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      check("busy_before_reset", {31'd0, Busy}, 32'd1);
      Reset_Load_Clear_n = 1'b0;
      #1;
      check("reset_midcalc", {Qval, Rval, 4'd0, Busy, Done, Div_By_Zero, Overflow}, 32'd0);
      @(negedge CLK);
      check("reset_midcalc_hold", {Qval, Rval, 4'd0, Busy, Done, Div_By_Zero, Overflow}, 32'd0);
      Reset_Load_Clear_n = 1'b1;
      run_op(8'd50, 8'd7, 1'b1, lat);
      check_result("after_reset", 8'd7, 8'd1, 1'b0, 1'b0, lat);
      to_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
